cfs_apb_regfile: RTL and testbench

Parametrised APB completer (slave) with a bank of memory-mapped registers, programmable wait states, error response and a built-in protocol checker. Sits behind the APB interface as the reusable register endpoint of a block. It generalises the fixed-width APB signal bundle to configurable data width, address width and register count. Adds wait-state insertion, `pslverr` generation and requester-side protocol-violation detection.

---
 rtl/cfs_apb_regfile.sv | 88 ++++++++
 tb/tb_cfs_apb_regfile.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cfs_apb_regfile.sv
// cfs_apb_regfile: parametrised APB completer with a register bank, wait states, pslverr and requester protocol checking
module cfs_apb_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_REGS = 8,
    parameter int WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
    input  logic                           pclk,
    input  logic                           reset_n,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic                           pwrite,
    input  logic                           psel,
    input  logic                           penable,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    output logic                           pready,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
    output logic                           protocol_err
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;
    localparam int LB = $clog2(DATA_WIDTH / 8);
    localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] AMASK = ADDR_WIDTH'((1 << LB) - 1);
    localparam logic [ADDR_WIDTH:0] NREG = (ADDR_WIDTH + 1)'(NUM_REGS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    logic [0:0]                          state;
    logic [3:0]                          cnt;
    logic [ADDR_WIDTH-1:0]               a_q;
    logic                                w_q;
    logic [DATA_WIDTH-1:0]               d_q;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] hw;
    logic [ADDR_WIDTH-1:0]               idx;
    logic [IW-1:0]                       sel;
    logic                                in_acc;
    logic                                setup;
    logic                                viol;
    logic                                done;
    logic                                ro;
    logic                                err;

    assign hw = hw_in;
    assign reg_q = regs;

    // The setup phase is the IDLE-state cycle with psel and no penable; ACCESS is the registered state after it.
    always_comb begin
        in_acc = state == ACCESS;
        setup = state == IDLE && psel && !penable;
        viol = (state == IDLE && penable) ||
               (in_acc && (!psel || !penable || paddr != a_q || pwrite != w_q || pwdata != d_q));
        done = in_acc && cnt == WS && !viol;
        idx = a_q >> LB;
        sel = idx[IW-1:0];
        ro = RO_MASK[sel];
        err = |(a_q & AMASK) || !({1'b0, idx} < NREG) || (w_q && ro);
        pready = done;
        pslverr = done && err;
        prdata = (done && !w_q && !err) ? (ro ? hw[sel] : regs[sel]) : '0;
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt <= '0;
            a_q <= '0;
            w_q <= 1'b0;
            d_q <= '0;
            regs <= '0;
            protocol_err <= 1'b0;
        end else begin
            protocol_err <= viol;
            state <= (setup || (in_acc && !done && !viol)) ? ACCESS : IDLE;
            cnt <= in_acc ? cnt + 4'd1 : 4'd0;
            if (setup) begin
                a_q <= paddr;
                w_q <= pwrite;
                d_q <= pwdata;
            end
            if (done && w_q && !err)
                regs[sel] <= d_q;
        end
    end
endmodule

// File: tb/tb_cfs_apb_regfile.sv
// tb_cfs_apb_regfile: scoreboard bench over four instances differing only in WAIT_STATES (0..3)
module tb_cfs_apb_regfile;
    typedef struct packed {
        logic [1:0]  t;
        logic        perr;
        logic        rd;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic         pclk;
    logic         reset_n;
    logic [15:0]  paddr;
    logic         pwrite;
    logic         psel;
    logic         penable;
    logic [31:0]  pwdata;
    logic [255:0] hw_in;
    int           tgt;
    logic         pready_v [4];
    logic [31:0]  prdata_v [4];
    logic         pslverr_v [4];
    logic [255:0] regq_v [4];
    logic         perr_v [4];
    exp_t         sb [$];
    exp_t         e_m;
    logic [255:0] snap;
    int           nchk = 0;
    int           nfail = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        cfs_apb_regfile #(
            .DATA_WIDTH(32), .ADDR_WIDTH(16), .NUM_REGS(8), .WAIT_STATES(g), .RO_MASK(8'h01)
        ) u_dut (
            .pclk(pclk),
            .reset_n(reset_n),
            .paddr(paddr),
            .pwrite(pwrite),
            .psel(psel && tgt == g),
            .penable(penable && tgt == g),
            .pwdata(pwdata),
            .pready(pready_v[g]),
            .prdata(prdata_v[g]),
            .pslverr(pslverr_v[g]),
            .reg_q(regq_v[g]),
            .hw_in(hw_in),
            .protocol_err(perr_v[g])
        );
    end

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        for (int i = 0; i < 4; i++) begin
            nchk++;
            if (pready_v[i] || perr_v[i]) begin
                if (sb.size() == 0) begin
                    nfail++;
                    $display("FAIL unexpected_out inst %0d: pready=%0b protocol_err=%0b, nothing expected", i, pready_v[i], perr_v[i]);
                end else begin
                    e_m = sb.pop_front();
                    if (!(32'(e_m.t) == i && e_m.perr == perr_v[i] && pready_v[i] == !e_m.perr &&
                          pslverr_v[i] == e_m.err && (!e_m.rd || prdata_v[i] == e_m.data))) begin
                        nfail++;
                        $display("FAIL response inst %0d: got pready=%0b perr=%0b pslverr=%0b prdata=%h, need inst %0d perr=%0b pslverr=%0b prdata=%h",
                                 i, pready_v[i], perr_v[i], pslverr_v[i], prdata_v[i], e_m.t, e_m.perr, e_m.err, e_m.data);
                    end
                end
            end else if (pslverr_v[i] || prdata_v[i] != 32'h0) begin
                nfail++;
                $display("FAIL idle_out inst %0d: pslverr=%0b prdata=%h, need 0 without pready", i, pslverr_v[i], prdata_v[i]);
            end
        end
    end

    task automatic xfer(input int t, input logic w, input logic [15:0] a, input logic [31:0] d,
                        input logic ee, input logic [31:0] ed, input logic b2b);
        int cyc;
        bit ok;
        sb.push_back('{t: 2'(t), perr: 1'b0, rd: !w, err: ee, data: ed});
        @(posedge pclk); #1;
        tgt = t; psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        cyc = 2;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge pclk);
            if (pready_v[t]) begin
                ok = 1'b1;
                break;
            end
            @(posedge pclk); #1;
            cyc++;
        end
        nchk++;
        if (!ok || cyc != 2 + t) begin
            nfail++;
            $display("FAIL xfer_len inst %0d addr %h: got %0d cycles (completed=%0b), need %0d", t, a, cyc, ok, 2 + t);
        end
        if (!b2b) begin
            @(posedge pclk); #1;
            psel = 1'b0; penable = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] need);
        nchk++;
        if (got !== need) begin
            nfail++;
            $display("FAIL %s: got %h, need %h", name, got, need);
        end
    endtask

    initial begin
        reset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; tgt = 0;
        hw_in = {32'hC0DE0007, 32'hC0DE0006, 32'hC0DE0005, 32'hC0DE0004,
                 32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'h12345678};
        repeat (3) @(posedge pclk);
        #1;
        for (int i = 0; i < 4; i++)
            check("reset_state", {regq_v[i], prdata_v[i], 5'(pready_v[i]), 5'(pslverr_v[i]), 5'(perr_v[i])}, '0);
        reset_n = 1'b1;

        // Reset in the middle of a 3-wait-state write
        xfer(3, 1'b1, 16'h0004, 32'h0000A5A5, 1'b0, 32'h0, 1'b0);
        check("pre_reset_reg1", 256'(regq_v[3][63:32]), 256'(32'h0000A5A5));
        @(posedge pclk); #1;
        tgt = 3; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0004; pwdata = 32'h000055AA;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        reset_n = 1'b0;
        #1;
        check("async_reset", {regq_v[3], prdata_v[3], 5'(pready_v[3]), 5'(pslverr_v[3])}, '0);
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        reset_n = 1'b1;
        repeat (6) @(posedge pclk);
        #1;
        check("no_write_after_reset", regq_v[3], '0);

        // Basic write/read with zero wait states
        xfer(0, 1'b1, 16'h0008, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
        check("write_reg2", 256'(regq_v[0][95:64]), 256'(32'hDEADBEEF));
        xfer(0, 1'b0, 16'h0008, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);
        xfer(0, 1'b1, 16'h001C, 32'hCAFE0007, 1'b0, 32'h0, 1'b0);
        xfer(0, 1'b0, 16'h001C, 32'h0, 1'b0, 32'hCAFE0007, 1'b0);
        check("write_reg7", 256'(regq_v[0][255:224]), 256'(32'hCAFE0007));

        // Two wait states: read-only register 0 returns hw_in
        xfer(2, 1'b0, 16'h0000, 32'h0, 1'b0, 32'h12345678, 1'b0);

        // Error responses
        snap = regq_v[0];
        xfer(0, 1'b1, 16'h0000, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0);
        xfer(0, 1'b1, 16'h0002, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0);
        xfer(0, 1'b1, 16'h0020, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0);
        check("err_writes_no_change", regq_v[0], snap);
        xfer(0, 1'b0, 16'h0000, 32'h0, 1'b0, 32'h12345678, 1'b0);
        xfer(0, 1'b0, 16'h0002, 32'h0, 1'b1, 32'h0, 1'b0);
        xfer(0, 1'b0, 16'h0020, 32'h0, 1'b1, 32'h0, 1'b0);

        // Protocol violations on the one-wait-state instance
        xfer(1, 1'b1, 16'h0004, 32'h00000077, 1'b0, 32'h0, 1'b0);
        @(posedge pclk); #1;
        tgt = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0004; pwdata = 32'h00000099;
        sb.push_back('{t: 2'd1, perr: 1'b1, rd: 1'b0, err: 1'b0, data: 32'h0});
        @(posedge pclk); #1;
        penable = 1'b1; paddr = 16'h0008;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        check("perr_no_write", 256'(regq_v[1][95:32]), 256'({32'h0, 32'h00000077}));
        sb.push_back('{t: 2'd1, perr: 1'b1, rd: 1'b0, err: 1'b0, data: 32'h0});
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        penable = 1'b0;
        repeat (2) @(posedge pclk);

        // Back-to-back write then read, no idle cycle in between
        xfer(0, 1'b1, 16'h0004, 32'h00000011, 1'b0, 32'h0, 1'b1);
        xfer(0, 1'b0, 16'h0004, 32'h0, 1'b0, 32'h00000011, 1'b0);

        repeat (4) @(negedge pclk);
        nchk++;
        if (sb.size() != 0) begin
            nfail++;
            $display("FAIL scoreboard_drain: got %0d pending responses, need 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
